// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with counter-timed memory waits.
// Define BNE_EN to decode opcode 0x05 (bne) as an inverted-condition branch.
module mips_multicycle_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNot,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       AWrite,
  output logic       BWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [3:0] state_out,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4, MEM_WR = 4'd5,
    R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, TRAP = 4'd10
  } state_t;
  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_not, ior_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, alu_src_a, reg_write, reg_dst, a_write, b_write;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;
  localparam logic [2:0] ALU_LOAD = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3, ALU_XOR = 3'd6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY);
  // Outputs are registered: they are derived from the next state so they line up with state_q.
  function automatic ctrl_t ctrl_of(input state_t s, input logic last, input logic [5:0] fn, input logic bn);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.ir_write  = last;
        c.pc_write  = last;
      end
      DECODE: begin
        c.a_write   = 1'b1;
        c.b_write   = 1'b1;
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = fn == 6'h20 ? ALU_ADD : fn == 6'h22 ? ALU_SUB :
                      fn == 6'h24 ? ALU_AND : fn == 6'h26 ? ALU_XOR : ALU_LOAD;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch_not    = bn;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             bne, r_ok, unused_zero;
`ifdef BNE_EN
  assign bne = opcode == 6'h05;
`else
  assign bne = 1'b0;
`endif
  assign r_ok        = funct inside {6'h20, 6'h22, 6'h24, 6'h26};
  assign unused_zero = zero;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      FETCH: begin
        state_d = cnt_q == LAST ? DECODE : FETCH;
        cnt_d   = cnt_q == LAST ? '0 : cnt_q + CNT_W'(1);
      end
      DECODE:
        state_d = opcode == 6'h00 ? R_EXEC :
                  (opcode == 6'h23 || opcode == 6'h2B) ? MEM_ADDR :
                  (opcode == 6'h04 || bne) ? BRANCH :
                  opcode == 6'h02 ? JUMP : TRAP;
      MEM_ADDR: state_d = opcode == 6'h2B ? MEM_WR : MEM_RD;
      MEM_RD: begin
        state_d = cnt_q == LAST ? MEM_WB : MEM_RD;
        cnt_d   = cnt_q == LAST ? '0 : cnt_q + CNT_W'(1);
      end
      R_EXEC:  state_d = r_ok ? R_WB : TRAP;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
    ctrl_d    = ctrl_of(state_d, cnt_d == LAST, funct, bne);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= ctrl_of(FETCH, LAST == '0, 6'h00, 1'b0);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end
  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign BranchNot   = ctrl_q.branch_not;
  assign IorD        = ctrl_q.ior_d;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign IRWrite     = ctrl_q.ir_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign AWrite      = ctrl_q.a_write;
  assign BWrite      = ctrl_q.b_write;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign state_out   = state_q;
  assign illegal     = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: trace-model bench for the multicycle control unit (L=2 main DUT, L=0 lw DUT).
module tb_mips_multicycle_ctrl;
  localparam int L = 2;
  localparam int PCW = 0, PCWC = 1, BN = 2, IORD = 3, MR = 4, MW = 5, M2R = 6, IRW = 7, SA = 8;
  localparam int RW = 9, RD = 10, AW = 11, BW = 12, PCS = 13, SB = 15, AOP = 17, ST = 20, ILL = 24;
  logic       clk = 1'b0;
  logic       reset = 1'b1, reset0 = 1'b1;
  logic [5:0] opcode = 6'h00, funct = 6'h20;
  logic [5:0] opcode0 = 6'h23, funct0 = 6'h00;
  logic       zero = 1'b0;
  wire [24:0] o2, o0;
  int         tests = 0, fails = 0;
  logic [24:0] q[$];
  always #5 clk = ~clk;
  mips_multicycle_ctrl #(.MEM_LATENCY(L), .CNT_W(4)) u2 (
    .clock(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(o2[PCW]), .PCWriteCond(o2[PCWC]), .BranchNot(o2[BN]), .IorD(o2[IORD]),
    .MemRead(o2[MR]), .MemWrite(o2[MW]), .MemtoReg(o2[M2R]), .IRWrite(o2[IRW]),
    .ALUSrcA(o2[SA]), .RegWrite(o2[RW]), .RegDst(o2[RD]), .AWrite(o2[AW]), .BWrite(o2[BW]),
    .PCSource(o2[14:13]), .ALUSrcB(o2[16:15]), .ALUOp(o2[19:17]), .state_out(o2[23:20]),
    .illegal(o2[ILL]));
  mips_multicycle_ctrl #(.MEM_LATENCY(0), .CNT_W(4)) u0 (
    .clock(clk), .reset(reset0), .opcode(opcode0), .funct(funct0), .zero(zero),
    .PCWrite(o0[PCW]), .PCWriteCond(o0[PCWC]), .BranchNot(o0[BN]), .IorD(o0[IORD]),
    .MemRead(o0[MR]), .MemWrite(o0[MW]), .MemtoReg(o0[M2R]), .IRWrite(o0[IRW]),
    .ALUSrcA(o0[SA]), .RegWrite(o0[RW]), .RegDst(o0[RD]), .AWrite(o0[AW]), .BWrite(o0[BW]),
    .PCSource(o0[14:13]), .ALUSrcB(o0[16:15]), .ALUOp(o0[19:17]), .state_out(o0[23:20]),
    .illegal(o0[ILL]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // Expected output word for one cycle in a given state.
  function automatic logic [24:0] w(input int st, input bit last, input logic [2:0] aop, input bit bn);
    logic [24:0] v;
    v = '0;
    case (st)
      0: begin v[MR] = 1; v[SB+:2] = 2'b01; v[AOP+:3] = 3'd1; v[IRW] = last; v[PCW] = last; end
      1: begin v[AW] = 1; v[BW] = 1; v[SB+:2] = 2'b11; v[AOP+:3] = 3'd1; end
      2: begin v[SA] = 1; v[SB+:2] = 2'b10; v[AOP+:3] = 3'd1; end
      3: begin v[MR] = 1; v[IORD] = 1; end
      4: begin v[RW] = 1; v[M2R] = 1; end
      5: begin v[MW] = 1; v[IORD] = 1; end
      6: begin v[SA] = 1; v[AOP+:3] = aop; end
      7: begin v[RW] = 1; v[RD] = 1; end
      8: begin v[SA] = 1; v[AOP+:3] = 3'd2; v[PCWC] = 1; v[PCS+:2] = 2'b01; v[BN] = bn; end
      9: begin v[PCW] = 1; v[PCS+:2] = 2'b10; end
      default: ;
    endcase
    v[ST+:4] = 4'(st);
    v[ILL]   = st == 10;
    return v;
  endfunction
  task automatic push_trap();
    repeat (3) q.push_back(w(10, 0, 0, 0));
  endtask
  task automatic push_fetch_decode();
    for (int i = 0; i <= L; i++) q.push_back(w(0, i == L, 0, 0));
    q.push_back(w(1, 0, 0, 0));
  endtask
  // Whole-instruction trace from the ISA rules.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn);
    push_fetch_decode();
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin q.push_back(w(6, 0, 3'd1, 0)); q.push_back(w(7, 0, 0, 0)); end
        6'h22: begin q.push_back(w(6, 0, 3'd2, 0)); q.push_back(w(7, 0, 0, 0)); end
        6'h24: begin q.push_back(w(6, 0, 3'd3, 0)); q.push_back(w(7, 0, 0, 0)); end
        6'h26: begin q.push_back(w(6, 0, 3'd6, 0)); q.push_back(w(7, 0, 0, 0)); end
        default: begin q.push_back(w(6, 0, 3'd0, 0)); push_trap(); end
      endcase
    end else if (op == 6'h23) begin
      q.push_back(w(2, 0, 0, 0));
      for (int i = 0; i <= L; i++) q.push_back(w(3, 0, 0, 0));
      q.push_back(w(4, 0, 0, 0));
    end else if (op == 6'h2B) begin
      q.push_back(w(2, 0, 0, 0));
      q.push_back(w(5, 0, 0, 0));
    end else if (op == 6'h04) q.push_back(w(8, 0, 0, 0));
    else if (op == 6'h02) q.push_back(w(9, 0, 0, 0));
`ifdef BNE_EN
    else if (op == 6'h05) q.push_back(w(8, 0, 0, 1));
`endif
    else push_trap();
  endtask
  task automatic wait_empty();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("trace_drained", 32'(q.size()), 0);
    q.delete();
    #1;
  endtask
  // Precondition and postcondition: posedge+1, DUT in FETCH with cnt=0.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int exp_len);
    bit trap;
    opcode = op;
    funct  = fn;
    gen(op, fn);
    chk($sformatf("len_op%h_fn%h", op, fn), 32'(q.size()), 32'(exp_len));
    trap = q[q.size()-1][ST+:4] == 4'd10;
    wait_empty();
    if (trap) begin
      reset = 1'b1;
      @(negedge clk);
      chk("trap_reset_state", 32'(o2[ST+:4]), 0);
      chk("trap_reset_illegal", 32'(o2[ILL]), 0);
      @(posedge clk);
      #1 reset = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [24:0] e;
      e = q.pop_front();
      chk($sformatf("cycle_st%0d", e[ST+:4]), 32'(o2), 32'(e));
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    chk("pin_fetch_last", 32'(w(0, 1, 0, 0)), 32'h0028091);
    chk("pin_r_wb", 32'(w(7, 0, 0, 0)), 32'h0700600);
    chk("pin_branch", 32'(w(8, 0, 0, 0)), 32'h0842102);
    chk("pin_jump", 32'(w(9, 0, 0, 0)), 32'h0904001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_word", 32'(o2), 32'(w(0, 0, 0, 0)));
    @(posedge clk);
    #1 reset = 1'b0;
    run(6'h00, 6'h20, 6);
    run(6'h00, 6'h22, 6);
    run(6'h00, 6'h24, 6);
    run(6'h00, 6'h26, 6);
    run(6'h23, 6'h00, 9);
    run(6'h2B, 6'h00, 6);
    run(6'h04, 6'h00, 5);
    run(6'h02, 6'h00, 5);
`ifdef BNE_EN
    run(6'h05, 6'h00, 5);
`else
    run(6'h05, 6'h00, 7);
`endif
    run(6'h3F, 6'h00, 7);
    run(6'h00, 6'h00, 8);
    opcode = 6'h23;
    funct  = 6'h00;
    push_fetch_decode();
    q.push_back(w(2, 0, 0, 0));
    q.push_back(w(3, 0, 0, 0));
    q.push_back(w(3, 0, 0, 0));
    wait_empty();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midwait_reset_state", 32'(o2[ST+:4]), 0);
      chk("midwait_no_regwrite", 32'(o2[RW]), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    run(6'h00, 6'h20, 6);
    reset0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("l0_lw_state%0d", k), 32'(o0[ST+:4]), 32'(k));
      if (k == 0) chk("l0_fetch_irwrite", 32'(o0[IRW]), 1);
      if (k == 4) chk("l0_memwb_m2r_rw", 32'({o0[M2R], o0[RW]}), 32'b11);
    end
    @(negedge clk);
    chk("l0_back_fetch", 32'(o0[ST+:4]), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
